// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write-to-read bypass
// and a per-register busy scoreboard for in-flight producers. Register 0 reads zero.
module regfile_mp #(
  parameter int W      = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NR*AW-1:0]  rd_addr_i,
  output logic [NR*W-1:0]   rd_data_o,
  output logic [NR-1:0]     rd_busy_o,
  input  logic              wr0_en_i,
  input  logic [AW-1:0]     wr0_addr_i,
  input  logic [W-1:0]      wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [AW-1:0]     wr1_addr_i,
  input  logic [W-1:0]      wr1_data_i,
  input  logic              rsv_en_i,
  input  logic [AW-1:0]     rsv_addr_i,
  input  logic              flush_i
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;

  logic wr0_act, wr1_act;
  assign wr0_act = wr0_en_i && (wr0_addr_i != '0);
  assign wr1_act = wr1_en_i && (wr1_addr_i != '0);

  // Scoreboard next state: flush, then reserve, then write completion, else hold.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves busy_next unassigned (no latch).
    busy_next = busy;
    busy_next[0] = 1'b0;
    for (int r = 1; r < DEPTH; r++) begin
      if (flush_i)
        busy_next[r] = 1'b0;
      else if (rsv_en_i && (rsv_addr_i == AW'(r)))
        busy_next[r] = 1'b1;
      else if ((wr0_act && (wr0_addr_i == AW'(r))) || (wr1_act && (wr1_addr_i == AW'(r))))
        busy_next[r] = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the array is reset explicitly because reset must zero every architectural register.
      for (int r = 0; r < DEPTH; r++)
        mem[r] <= '0;
      busy <= '0;
    end else begin
      // NOTE: non-blocking writes; the later statement wins, so write port 1 has collision priority.
      if (wr0_act) mem[wr0_addr_i] <= wr0_data_i;
      if (wr1_act) mem[wr1_addr_i] <= wr1_data_i;
      busy <= busy_next;
    end
  end

  // Read ports: stored value, optionally overridden by same-cycle write data.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NR; k++) begin
      logic [AW-1:0] a;
      logic [W-1:0]  d;
      a = rd_addr_i[k*AW +: AW];
      d = mem[a];
      if (BYPASS) begin
        if (wr0_act && (wr0_addr_i == a)) d = wr0_data_i;
        if (wr1_act && (wr1_addr_i == a)) d = wr1_data_i;
      end
      if (a == '0) d = '0;
      rd_data_o[k*W +: W] = d;
      rd_busy_o[k]        = (a != '0) && busy[a];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (bypass on / off) share all inputs
// and are checked against hand-computed values.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR*W-1:0]   data_a, data_b;
  logic [NR-1:0]     busy_a, busy_b;
  logic              wr0_en = 1'b0, wr1_en = 1'b0, rsv_en = 1'b0, flush = 1'b0;
  logic [AW-1:0]     wr0_addr = '0, wr1_addr = '0, rsv_addr = '0;
  logic [W-1:0]      wr0_data = '0, wr1_data = '0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_mp #(.W(W), .AW(AW), .NR(NR), .BYPASS(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(data_a), .rd_busy_o(busy_a),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush)
  );

  regfile_mp #(.W(W), .AW(AW), .NR(NR), .BYPASS(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(data_b), .rd_busy_o(busy_b),
    .wr0_en_i(wr0_en), .wr0_addr_i(wr0_addr), .wr0_data_i(wr0_data),
    .wr1_en_i(wr1_en), .wr1_addr_i(wr1_addr), .wr1_data_i(wr1_data),
    .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .flush_i(flush)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr0_en = 1'b1; wr0_addr = a; wr0_data = d;
  endtask

  task automatic wr1(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr1_en = 1'b1; wr1_addr = a; wr1_data = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset: write r5, then reset with competing write and reserve
    wr0(5'd5, 32'hDEADBEEF);
    tick(); idle();
    set_rd(0, 5'd5);
    #1 check("r5_written", data_a[31:0], 32'hDEADBEEF);
    rst = 1'b1;
    wr1(5'd5, 32'h55); rsv(5'd5);
    set_rd(1, 5'd5); set_rd(2, 5'd9); set_rd(3, 5'd31);
    tick(); idle();
    #1 check("rst_held_r5", data_b[31:0], 32'h0);
    rst = 1'b0;
    #1 check("rst_r5_data", data_a[31:0], 32'h0);
    check("rst_busy_all", {busy_a, busy_b}, 8'h00);

    // Zero register: write and reserve r0
    set_rd(0, 5'd0);
    wr0(5'd0, 32'h12345678); rsv(5'd0);
    #1 check("r0_bypass", data_a[31:0], 32'h0);
    tick(); idle();
    #1 check("r0_data", data_a[31:0], 32'h0);
    check("r0_busy", busy_a[0], 1'b0);

    // Collision and bypass on r7
    wr0(5'd7, 32'h33);
    tick(); idle();
    set_rd(0, 5'd7);
    wr0(5'd7, 32'h11); wr1(5'd7, 32'h22);
    #1 check("coll_bypass_on", data_a[31:0], 32'h22);
    check("coll_bypass_off", data_b[31:0], 32'h33);
    tick(); idle();
    #1 check("coll_next_on", data_a[31:0], 32'h22);
    check("coll_next_off", data_b[31:0], 32'h22);

    // Bypass through write port 0 alone on read port 2
    set_rd(2, 5'd8);
    wr0(5'd8, 32'h44);
    #1 check("byp_p0_on", data_a[95:64], 32'h44);
    check("byp_p0_off", data_b[95:64], 32'h0);
    tick(); idle();

    // Scoreboard on r3
    set_rd(1, 5'd3);
    rsv(5'd3);
    #1 check("busy_no_bypass", busy_a[1], 1'b0);
    tick(); idle();
    #1 check("r3_busy", busy_a[1], 1'b1);
    wr1(5'd3, 32'hA5);
    tick(); idle();
    #1 check("r3_clear", busy_b[1], 1'b0);
    check("r3_data", data_b[63:32], 32'hA5);

    // Reserve and write r4 together: stays busy with new data
    set_rd(3, 5'd4);
    rsv(5'd4); wr0(5'd4, 32'h99);
    tick(); idle();
    #1 check("r4_busy", busy_a[3], 1'b1);
    check("r4_data", data_a[127:96], 32'h99);

    // Reserve r6 with flush: flush wins, and r4 clears too
    set_rd(2, 5'd6);
    rsv(5'd6); flush = 1'b1;
    tick(); idle();
    #1 check("flush_busy", {busy_a[3:2], busy_b[3:2]}, 4'b0000);

    // Highest address
    set_rd(2, 5'd31);
    wr1(5'd31, 32'hFFFFFFFF);
    tick(); idle();
    #1 check("r31_data", data_b[95:64], 32'hFFFFFFFF);

    // Multi-port read of r1, r2, r1, r0 (port 0..3)
    wr0(5'd1, 32'd1); wr1(5'd2, 32'd2);
    tick(); idle();
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd1); set_rd(3, 5'd0);
    #1 check("multiport", data_a, {32'd0, 32'd1, 32'd2, 32'd1});
    check("multiport_off", data_b, {32'd0, 32'd1, 32'd2, 32'd1});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard. It is the next-generation register file for the decode/execute datapath: configurable width, depth and read-port count, two write ports with defined collision priority, same-cycle write-to-read bypass, and reservation tracking for in-flight producers. Register 0 is hardwired to zero.

## Interface
- `W`, 32, data width in bits
- `AW`, 5, address width; depth = 2**AW registers
- `NR`, 2, number of read ports (1..8)
- `BYPASS`, 1, 1 = a read returns same-cycle write data for a matching address; 0 = a read returns stored contents only

- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `rd_addr_i`  in  NR*AW  read addresses; port k occupies bits [k*AW +: AW]
- `rd_data_o`  out  NR*W  read data; port k occupies bits [k*W +: W]; combinational
- `rd_busy_o`  out  NR  busy flag of the register addressed by each read port; combinational
- `wr0_en_i`, `wr1_en_i`  in  1  write enables for write ports 0 and 1
- `wr0_addr_i`, `wr1_addr_i`  in  AW  write addresses
- `wr0_data_i`, `wr1_data_i`  in  W  write data
- `rsv_en_i`  in  1  reserve request: marks a destination register busy
- `rsv_addr_i`  in  AW  register to reserve
- `flush_i`  in  1  clears all busy bits

## Operation
- Storage: 2**AW x W registers and 2**AW busy bits.
- Reset: while `rst_i`=1 at a clock edge, all registers and busy bits become 0. Reset overrides every other input that cycle.
- Register 0: writes are ignored, reservations are ignored, reads return 0, and busy reads 0 at all times.
- Write: when `wrN_en_i`=1 and the address is nonzero, the register takes `wrN_data_i` at the edge.
- Write collision: if both ports write the same nonzero address, port 1 wins. The register takes `wr1_data_i`.
- Read: `rd_data_o[k]` = mem[`rd_addr_i[k]`].
- Bypass (`BYPASS`=1): if a write port is enabled to the same nonzero address as a read port, that read port returns the write data in the same cycle. Port 1 takes priority over port 0. With `BYPASS`=0, the read returns the old contents.
- Scoreboard, next-state per register r≠0, in priority order:
  1. `flush_i`=1 → busy 0
  2. `rsv_en_i`=1 and `rsv_addr_i`=r → busy 1
  3. either write port enabled to r → busy 0
  4. otherwise hold
- Reserve and write to the same register in the same cycle leave it busy: the new producer supersedes the completing one.
- `rd_busy_o[k]` reflects the registered busy bit. There is no bypass on busy.
- Write data is accepted whether or not the target register is busy. Only the busy bit is affected.

## Timing
- Read data and busy flags are combinational from addresses, with zero latency.
- A write is visible from the following cycle, or in the same cycle through bypass.
- A busy bit changes one cycle after the reserve, write or flush that causes it.
- All outputs reflect zeroed state in the cycle after the reset edge, and for as long as reset is held.
- Reset asserted mid-operation discards same-cycle writes and reservations.
- Address wrap-around does not occur. Every AW-bit address is valid.

## Test plan
- Reset: write 0xDEADBEEF to r5, then assert `rst_i` for 1 cycle → the following cycle r5 reads 0 and all `rd_busy_o`=0.
- Zero register: `wr0` writes 0x12345678 to r0 and `rsv_en_i` targets r0 → r0 reads 0 and busy is 0 next cycle.
- Collision and bypass: in one cycle, `wr0`(r7, 0x11) and `wr1`(r7, 0x22), with read port 0 on r7 → same-cycle read 0x22 when `BYPASS`=1 and the old value when `BYPASS`=0; next cycle r7 reads 0x22 in both cases.
- Scoreboard: reserve r3 → `rd_busy_o`=1 from the next cycle. `wr1` to r3 with 0xA5 → busy 0 the cycle after, data 0xA5.
- Simultaneous events: reserve r4 and write r4 in the same cycle → r4 ends busy with the new data. Reserve r6 with `flush_i`=1 → r6 not busy.
- Multi-port: with `NR`=4, reads of r1, r2, r1 and r0 after writes r1=1 and r2=2 → rd_data = {0, 1, 2, 1}, listed port 3 down to port 0.
